// File: rtl/mips_cpu_pkg.sv
// Shared types and default addresses for the MIPS core's program-counter sequencing.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_DELAY,
    PC_HALTED
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-transfer bus between the core pipeline (master) and the PC sequencer (slave).
interface pc_sequencer_if;
  logic        advance;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [3:0]  pc_4msb;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        active;
  logic        halted;
  logic        slot_violation;

  modport master (
    output advance, redirect_valid, redirect_target,
    input  pc, pc_plus4, pc_4msb, link_addr, in_delay_slot, active, halted, slot_violation
  );

  modport slave (
    input  advance, redirect_valid, redirect_target,
    output pc, pc_plus4, pc_4msb, link_addr, in_delay_slot, active, halted, slot_violation
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with MIPS branch-delay-slot sequencing and halt-on-jump-to-HALT_ADDR.
module pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  pc_state_t   r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_pending_target, w_pending_target_d;
  logic        r_slot_violation, w_slot_violation_d;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= PC_RUN;
      r_pc             <= RESET_VECTOR;
      r_pending_target <= 32'd0;
      r_slot_violation <= 1'b0;
    end else begin
      r_state          <= w_state_d;
      r_pc             <= w_pc_d;
      r_pending_target <= w_pending_target_d;
      r_slot_violation <= w_slot_violation_d;
    end
  end

  always_comb begin
    w_state_d          = r_state;
    w_pc_d             = r_pc;
    w_pending_target_d = r_pending_target;
    w_slot_violation_d = r_slot_violation;

    case (r_state)
      PC_RUN: begin
        if (bus.advance) begin
          w_pc_d = w_pc_plus4;
          if (bus.redirect_valid) begin
            w_pending_target_d = bus.redirect_target;
            w_state_d          = PC_DELAY;
          end
        end
      end
      PC_DELAY: begin
        if (bus.advance) begin
          w_pc_d = r_pending_target;
          // A transfer in the delay slot is dropped; only the violation is recorded.
          if (bus.redirect_valid) w_slot_violation_d = 1'b1;
          w_state_d = (r_pending_target == HALT_ADDR) ? PC_HALTED : PC_RUN;
        end
      end
      PC_HALTED: begin
        w_pc_d = HALT_ADDR;
      end
      default: begin
        w_state_d = PC_RUN;
      end
    endcase
  end

  assign bus.pc             = r_pc;
  assign bus.pc_plus4       = w_pc_plus4;
  assign bus.pc_4msb        = w_pc_plus4[31:28];
  assign bus.link_addr      = r_pc + 32'd8;
  assign bus.in_delay_slot  = (r_state == PC_DELAY);
  assign bus.active         = (r_state != PC_HALTED);
  assign bus.halted         = (r_state == PC_HALTED);
  assign bus.slot_violation = r_slot_violation;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer, plus reset corner-case sequences.
module tb_pc_sequencer;

  logic clk;
  logic reset;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        adv;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_ds;
    logic        exp_halt;
    logic        exp_sv;
  } vec_t;

  localparam int NumVec = 25;
  vec_t vecs[NumVec];

  int checks;
  int errors;

  function automatic vec_t mk(logic adv, logic rv, logic [31:0] tgt, logic [31:0] pc,
                              logic ds, logic halt, logic sv);
    vec_t v;
    v.adv      = adv;
    v.rv       = rv;
    v.tgt      = tgt;
    v.exp_pc   = pc;
    v.exp_ds   = ds;
    v.exp_halt = halt;
    v.exp_sv   = sv;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic ds,
                             input logic halt, input logic sv);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    cmp({tag, " pc"}, bus.pc, pc);
    cmp({tag, " pc_plus4"}, bus.pc_plus4, p4);
    cmp({tag, " pc_4msb"}, {28'd0, bus.pc_4msb}, {28'd0, p4[31:28]});
    cmp({tag, " link_addr"}, bus.link_addr, pc + 32'd8);
    cmp({tag, " in_delay_slot"}, {31'd0, bus.in_delay_slot}, {31'd0, ds});
    cmp({tag, " active"}, {31'd0, bus.active}, {31'd0, ~halt});
    cmp({tag, " halted"}, {31'd0, bus.halted}, {31'd0, halt});
    cmp({tag, " slot_violation"}, {31'd0, bus.slot_violation}, {31'd0, sv});
  endtask

  task automatic step(input logic adv, input logic rv, input logic [31:0] tgt);
    @(negedge clk);
    bus.advance         = adv;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.advance        = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.advance         = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;

    //             adv   rv    tgt            pc             ds    halt  sv
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,        32'hBFC00004, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,        32'hBFC00008, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,        32'hBFC0000C, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 32'hDEADBEEC, 32'hBFC0000C, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,        32'hBFC00010, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 32'hBFC00100, 32'hBFC00014, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,        32'hBFC00100, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 32'hBFC00200, 32'hBFC00104, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,        32'hBFC00104, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 32'h00000055, 32'hBFC00104, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,        32'hBFC00104, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, 32'h00000000, 32'hBFC00104, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,        32'hBFC00104, 1'b1, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,        32'hBFC00200, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, 32'h12340000, 32'hBFC00204, 1'b1, 1'b0, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, 32'h12345678, 32'h12340000, 1'b0, 1'b0, 1'b1);
    vecs[16] = mk(1'b1, 1'b0, 32'h0,        32'h12340004, 1'b0, 1'b0, 1'b1);
    vecs[17] = mk(1'b1, 1'b1, 32'hFFFFFFFC, 32'h12340008, 1'b1, 1'b0, 1'b1);
    vecs[18] = mk(1'b1, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,        32'h00000000, 1'b0, 1'b0, 1'b1);
    vecs[20] = mk(1'b1, 1'b0, 32'h0,        32'h00000004, 1'b0, 1'b0, 1'b1);
    vecs[21] = mk(1'b1, 1'b1, 32'h00000000, 32'h00000008, 1'b1, 1'b0, 1'b1);
    vecs[22] = mk(1'b1, 1'b0, 32'h0,        32'h00000000, 1'b0, 1'b1, 1'b1);
    vecs[23] = mk(1'b1, 1'b1, 32'h00000100, 32'h00000000, 1'b0, 1'b1, 1'b1);
    vecs[24] = mk(1'b1, 1'b0, 32'h0,        32'h00000000, 1'b0, 1'b1, 1'b1);

    #12;
    check_state("reset_held", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("reset_released", 32'hBFC00000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NumVec; i++) begin
      step(vecs[i].adv, vecs[i].rv, vecs[i].tgt);
      check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_ds, vecs[i].exp_halt,
                  vecs[i].exp_sv);
    end

    // Leave halt by reset, create a sticky violation, then reset asynchronously in PC_DELAY.
    do_reset();
    #1;
    check_state("rst_from_halt", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h00400000);
    check_state("seq_a", 32'hBFC00004, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h00500000);
    check_state("seq_b", 32'h00400000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h00600000);
    check_state("seq_c", 32'h00400004, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    bus.advance        = 1'b0;
    bus.redirect_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_state("async_rst", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 32'h0);
    check_state("after_async_rst", 32'hBFC00004, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    check_state("pending_lost", 32'hBFC00008, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
